// File: rtl/div_issue_sequencer.sv
// Issue/response sequencer in front of the iterative DivisorUnit: resolves divide-by-zero and
// signed overflow locally, launches the divider otherwise. Optional result cache: DIV_SEQ_RESULT_CACHE_EN.
module div_issue_sequencer #(
  parameter int parallelism = 32,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [parallelism-1:0] req_a,
  input  logic [parallelism-1:0] req_b,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   div_valid,
  output logic                   div_usigned,
  output logic [parallelism-1:0] div_dividend,
  output logic [parallelism-1:0] div_divisor,
  input  logic [parallelism-1:0] div_quotient,
  input  logic [parallelism-1:0] div_reminder,
  input  logic                   div_res_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [parallelism-1:0] rsp_data,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_dz,
  output logic                   rsp_err,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [parallelism-1:0] MIN_VAL  = {1'b1, {(parallelism-1){1'b0}}};
  localparam logic [7:0]             CNT_LAST = 8'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [parallelism-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic                   dz_q, dz_d, err_q, err_d;
  logic                   div_valid_q, div_valid_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   cache_hit;

`ifdef DIV_SEQ_RESULT_CACHE_EN
  logic                   cache_valid_q, cache_valid_d, cache_uns_q, cache_uns_d;
  logic [parallelism-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [parallelism-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

  assign cache_hit = cache_valid_q && (cache_a_q == req_a) && (cache_b_q == req_b) &&
                     (cache_uns_q == req_op[0]);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    tag_d       = tag_q;
    dz_d        = dz_q;
    err_d       = err_q;
    div_valid_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
`ifdef DIV_SEQ_RESULT_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_uns_d   = cache_uns_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_quo_d   = cache_quo_q;
    cache_rem_d   = cache_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          tag_d = req_tag;
          dz_d  = 1'b0;
          err_d = 1'b0;
          if (req_b == '0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            dz_d        = 1'b1;
            data_d      = req_op[1] ? req_a : '1;
          end else if (!req_op[0] && req_a == MIN_VAL && req_b == '1) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            data_d      = req_op[1] ? '0 : MIN_VAL;
          end else if (cache_hit) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
`ifdef DIV_SEQ_RESULT_CACHE_EN
            data_d      = req_op[1] ? cache_rem_q : cache_quo_q;
`endif
          end else begin
            state_d     = ISSUE;
            div_valid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // res_ready wins over the timeout in the final counted cycle
        if (div_res_ready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          data_d      = op_q[1] ? div_reminder : div_quotient;
`ifdef DIV_SEQ_RESULT_CACHE_EN
          cache_valid_d = 1'b1;
          cache_uns_d   = op_q[0];
          cache_a_d     = a_q;
          cache_b_d     = b_q;
          cache_quo_d   = div_quotient;
          cache_rem_d   = div_reminder;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          data_d      = '0;
`ifdef DIV_SEQ_RESULT_CACHE_EN
          cache_valid_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      div_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
`ifdef DIV_SEQ_RESULT_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_uns_q   <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_quo_q   <= '0;
      cache_rem_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      dz_q        <= dz_d;
      err_q       <= err_d;
      div_valid_q <= div_valid_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
`ifdef DIV_SEQ_RESULT_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_uns_q   <= cache_uns_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_quo_q   <= cache_quo_d;
      cache_rem_q   <= cache_rem_d;
`endif
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign div_valid    = div_valid_q;
  assign div_usigned  = op_q[0];
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = data_q;
  assign rsp_tag      = tag_q;
  assign rsp_dz       = dz_q;
  assign rsp_err      = err_q;

endmodule
